// File: rtl/hazard_ctrl_if.sv
// Datapath-facing bundle of the hazard controller: register-match/control inputs
// plus forwarding selects, stall/flush controls and PC redirects.
interface hazard_ctrl_if;
    logic       Match_1E_M;
    logic       Match_1E_W;
    logic       Match_2E_M;
    logic       Match_2E_W;
    logic       Match_12D_E;
    logic       RegWriteM;
    logic       RegWriteW;
    logic       MemtoRegE;
    logic       BranchE;
    logic       CondTakenE;
    logic       prediction_E;
    logic       Correct_addr_prediction;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       StallF;
    logic       StallD;
    logic       FlushD;
    logic       FlushE;
    logic       BranchTakenE;
    logic       Branched_wrong;
    logic       BranchTakenE_for_predictor;

    modport master (
        output Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
        output RegWriteM, RegWriteW, MemtoRegE, BranchE, CondTakenE,
        output prediction_E, Correct_addr_prediction,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        input  BranchTakenE, Branched_wrong, BranchTakenE_for_predictor
    );

    modport slave (
        input  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
        input  RegWriteM, RegWriteW, MemtoRegE, BranchE, CondTakenE,
        input  prediction_E, Correct_addr_prediction,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        output BranchTakenE, Branched_wrong, BranchTakenE_for_predictor
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and branch-recovery controller: forwarding, load-use stall, branch
// resolution against the fetch-time prediction, one-cycle recovery, perf counters.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    hazard_ctrl_if.slave     hz,
    input  logic             perf_clear,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {RUN, RECOVER} state_t;

    state_t state;
    state_t state_next;
    logic   brv;
    logic   mis;
    logic   ldrstall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // RECOVER holds a flushed bubble in Execute, so branch and load-use terms are gated off
    always_comb begin
        state_next                    = RUN;
        brv                           = 1'b0;
        mis                           = 1'b0;
        ldrstall                      = 1'b0;
        hz.ForwardAE                  = 2'b00;
        hz.ForwardBE                  = 2'b00;
        hz.StallF                     = 1'b0;
        hz.StallD                     = 1'b0;
        hz.FlushD                     = 1'b0;
        hz.FlushE                     = 1'b0;
        hz.BranchTakenE               = 1'b0;
        hz.Branched_wrong             = 1'b0;
        hz.BranchTakenE_for_predictor = 1'b0;

        if (hz.Match_1E_M && hz.RegWriteM) begin
            hz.ForwardAE = 2'b10;
        end else if (hz.Match_1E_W && hz.RegWriteW) begin
            hz.ForwardAE = 2'b01;
        end

        if (hz.Match_2E_M && hz.RegWriteM) begin
            hz.ForwardBE = 2'b10;
        end else if (hz.Match_2E_W && hz.RegWriteW) begin
            hz.ForwardBE = 2'b01;
        end

        brv = hz.BranchE && (state == RUN);
        hz.BranchTakenE_for_predictor = brv && hz.CondTakenE;
        hz.BranchTakenE   = brv && hz.CondTakenE && !(hz.prediction_E && hz.Correct_addr_prediction);
        hz.Branched_wrong = brv && !hz.CondTakenE && hz.prediction_E;
        mis = hz.BranchTakenE || hz.Branched_wrong;
        ldrstall = hz.Match_12D_E && hz.MemtoRegE && !mis && (state == RUN);

        hz.StallF = ldrstall;
        hz.StallD = ldrstall;
        hz.FlushD = mis;
        hz.FlushE = mis || ldrstall;

        if (state == RUN && mis) begin
            state_next = RECOVER;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
            stall_cnt      <= '0;
        end else if (perf_clear) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
            stall_cnt      <= '0;
        end else begin
            if (brv) begin
                branch_cnt <= sat_inc(branch_cnt);
            end
            if (mis) begin
                mispredict_cnt <= sat_inc(mispredict_cnt);
            end
            if (ldrstall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with a 4-bit counter configuration so
// saturation is reachable in a few cycles.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             perf_clear;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;
    logic [CNT_W-1:0] stall_cnt;

    int compared;
    int mismatched;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .hz             (hz.slave),
        .perf_clear     (perf_clear),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive every input at once, then let combinational outputs settle
    task automatic applyStimulus(
        input logic m1m, input logic m1w, input logic m2m, input logic m2w,
        input logic rwm, input logic rww, input logic m12, input logic mem,
        input logic br, input logic ct, input logic pred, input logic corr,
        input logic clr
    );
        hz.Match_1E_M              = m1m;
        hz.Match_1E_W              = m1w;
        hz.Match_2E_M              = m2m;
        hz.Match_2E_W              = m2w;
        hz.RegWriteM               = rwm;
        hz.RegWriteW               = rww;
        hz.Match_12D_E             = m12;
        hz.MemtoRegE               = mem;
        hz.BranchE                 = br;
        hz.CondTakenE              = ct;
        hz.prediction_E            = pred;
        hz.Correct_addr_prediction = corr;
        perf_clear                 = clr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCounters(input string tag, input int b, input int m, input int s);
        checkOutput({tag, ".branch_cnt"}, 16'(branch_cnt), 16'(b));
        checkOutput({tag, ".mispredict_cnt"}, 16'(mispredict_cnt), 16'(m));
        checkOutput({tag, ".stall_cnt"}, 16'(stall_cnt), 16'(s));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        applyStimulus(0,0,0,0, 0,0,0,0, 0,0,0,0, 0);

        // Reset state: all outputs zero
        checkOutput("rst.ForwardAE", 16'(hz.ForwardAE), 16'd0);
        checkOutput("rst.ForwardBE", 16'(hz.ForwardBE), 16'd0);
        checkOutput("rst.StallF", 16'(hz.StallF), 16'd0);
        checkOutput("rst.FlushE", 16'(hz.FlushE), 16'd0);
        checkOutput("rst.BranchTakenE", 16'(hz.BranchTakenE), 16'd0);
        checkCounters("rst", 0, 0, 0);
        #11;
        reset = 1'b0;
        tick();

        // Forwarding priority on A, then B
        applyStimulus(1,1,0,0, 1,1,0,0, 0,0,0,0, 0);
        checkOutput("fwdA.mem", 16'(hz.ForwardAE), 16'd2);
        checkOutput("fwdB.idle", 16'(hz.ForwardBE), 16'd0);
        applyStimulus(1,1,0,0, 0,1,0,0, 0,0,0,0, 0);
        checkOutput("fwdA.wb", 16'(hz.ForwardAE), 16'd1);
        applyStimulus(1,1,0,0, 0,0,0,0, 0,0,0,0, 0);
        checkOutput("fwdA.none", 16'(hz.ForwardAE), 16'd0);
        applyStimulus(0,0,1,1, 1,1,0,0, 0,0,0,0, 0);
        checkOutput("fwdB.mem", 16'(hz.ForwardBE), 16'd2);
        checkOutput("fwdA.idle", 16'(hz.ForwardAE), 16'd0);
        applyStimulus(0,0,1,1, 0,1,0,0, 0,0,0,0, 0);
        checkOutput("fwdB.wb", 16'(hz.ForwardBE), 16'd1);
        applyStimulus(0,0,1,1, 0,0,0,0, 0,0,0,0, 0);
        checkOutput("fwdB.none", 16'(hz.ForwardBE), 16'd0);

        // Load-use stall
        applyStimulus(0,0,0,0, 0,0,1,1, 0,0,0,0, 0);
        checkOutput("ldr.StallF", 16'(hz.StallF), 16'd1);
        checkOutput("ldr.StallD", 16'(hz.StallD), 16'd1);
        checkOutput("ldr.FlushE", 16'(hz.FlushE), 16'd1);
        checkOutput("ldr.FlushD", 16'(hz.FlushD), 16'd0);
        checkOutput("ldr.cnt_before", 16'(stall_cnt), 16'd0);
        tick();
        checkCounters("ldr.after", 0, 0, 1);

        // Taken but not predicted, then BranchE ignored during RECOVER
        applyStimulus(0,0,0,0, 0,0,0,0, 1,1,0,0, 0);
        checkOutput("nopred.BranchTakenE", 16'(hz.BranchTakenE), 16'd1);
        checkOutput("nopred.Branched_wrong", 16'(hz.Branched_wrong), 16'd0);
        checkOutput("nopred.FlushD", 16'(hz.FlushD), 16'd1);
        checkOutput("nopred.FlushE", 16'(hz.FlushE), 16'd1);
        checkOutput("nopred.outcome", 16'(hz.BranchTakenE_for_predictor), 16'd1);
        tick();
        checkCounters("nopred.after", 1, 1, 1);
        checkOutput("recover.BranchTakenE", 16'(hz.BranchTakenE), 16'd0);
        checkOutput("recover.FlushD", 16'(hz.FlushD), 16'd0);
        checkOutput("recover.outcome", 16'(hz.BranchTakenE_for_predictor), 16'd0);
        tick();
        checkCounters("recover.after", 1, 1, 1);

        // Predicted taken but falls through
        applyStimulus(0,0,0,0, 0,0,0,0, 1,0,1,1, 0);
        checkOutput("fall.Branched_wrong", 16'(hz.Branched_wrong), 16'd1);
        checkOutput("fall.BranchTakenE", 16'(hz.BranchTakenE), 16'd0);
        checkOutput("fall.FlushE", 16'(hz.FlushE), 16'd1);
        tick();
        checkCounters("fall.after", 2, 2, 1);
        applyStimulus(0,0,0,0, 0,0,0,0, 0,0,0,0, 0);
        tick();

        // Predicted taken with wrong target
        applyStimulus(0,0,0,0, 0,0,0,0, 1,1,1,0, 0);
        checkOutput("badtgt.BranchTakenE", 16'(hz.BranchTakenE), 16'd1);
        checkOutput("badtgt.Branched_wrong", 16'(hz.Branched_wrong), 16'd0);
        tick();
        checkCounters("badtgt.after", 3, 3, 1);
        applyStimulus(0,0,0,0, 0,0,0,0, 0,0,0,0, 0);
        tick();

        // Correctly predicted taken: zero penalty
        applyStimulus(0,0,0,0, 0,0,0,0, 1,1,1,1, 0);
        checkOutput("good.BranchTakenE", 16'(hz.BranchTakenE), 16'd0);
        checkOutput("good.Branched_wrong", 16'(hz.Branched_wrong), 16'd0);
        checkOutput("good.FlushD", 16'(hz.FlushD), 16'd0);
        checkOutput("good.FlushE", 16'(hz.FlushE), 16'd0);
        checkOutput("good.outcome", 16'(hz.BranchTakenE_for_predictor), 16'd1);
        tick();
        checkCounters("good.after", 4, 3, 1);

        // Mispredict coincides with load-use: mispredict wins
        applyStimulus(0,0,0,0, 0,0,1,1, 1,1,0,0, 0);
        checkOutput("both.StallF", 16'(hz.StallF), 16'd0);
        checkOutput("both.StallD", 16'(hz.StallD), 16'd0);
        checkOutput("both.FlushD", 16'(hz.FlushD), 16'd1);
        checkOutput("both.FlushE", 16'(hz.FlushE), 16'd1);
        tick();
        checkCounters("both.after", 5, 4, 1);
        // Load-use condition is masked while recovering
        applyStimulus(0,0,0,0, 0,0,1,1, 0,0,0,0, 0);
        checkOutput("recover.StallF", 16'(hz.StallF), 16'd0);
        checkOutput("recover.FlushE", 16'(hz.FlushE), 16'd0);
        tick();
        checkCounters("recover2.after", 5, 4, 1);

        // Clear, then saturate with 17 mispredicts
        applyStimulus(0,0,0,0, 0,0,0,0, 0,0,0,0, 1);
        tick();
        checkCounters("clear", 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(0,0,0,0, 0,0,0,0, 1,1,0,0, 0);
            tick();
            applyStimulus(0,0,0,0, 0,0,0,0, 0,0,0,0, 0);
            tick();
        end
        checkCounters("sat", 15, 15, 0);

        // Clear wins over a simultaneous mispredict
        applyStimulus(0,0,0,0, 0,0,0,0, 1,1,0,0, 1);
        checkOutput("clrmis.BranchTakenE", 16'(hz.BranchTakenE), 16'd1);
        tick();
        checkCounters("clrmis", 0, 0, 0);
        applyStimulus(0,0,0,0, 0,0,0,0, 0,0,0,0, 0);
        tick();

        // Reset in the middle of RECOVER
        applyStimulus(0,0,0,0, 0,0,0,0, 1,1,0,0, 0);
        tick();
        checkCounters("prerst", 1, 1, 0);
        applyStimulus(0,0,0,0, 0,0,0,0, 0,0,0,0, 0);
        reset = 1'b1;
        #2;
        checkCounters("midrst", 0, 0, 0);
        reset = 1'b0;
        applyStimulus(0,0,0,0, 0,0,0,0, 1,1,0,0, 0);
        checkOutput("postrst.BranchTakenE", 16'(hz.BranchTakenE), 16'd1);
        checkOutput("postrst.FlushD", 16'(hz.FlushD), 16'd1);
        tick();
        checkCounters("postrst.after", 1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and branch-recovery controller for the five-stage ARM datapath with BTB/global branch prediction. It drives the datapath's operand-forwarding selects, the fetch/decode stall and flush controls, and the PC redirect controls. The redirect controls are `BranchTakenE` (taken redirect) and `Branched_wrong` (fall-through recovery). The block resolves each Execute-stage branch against the fetch-time prediction, runs a one-cycle recovery state after a misprediction, and keeps saturating performance counters.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W  in  1 each  register-address matches from the datapath
- Match_12D_E  in  1  Decode source matches the Execute destination
- RegWriteM, RegWriteW  in  1  register write enable in the Memory / Writeback stage
- MemtoRegE  in  1  Execute-stage instruction is a load
- BranchE  in  1  Execute-stage instruction is a branch
- CondTakenE  in  1  branch condition evaluated true in Execute
- prediction_E  in  1  prediction carried to Execute from fetch (hit & taken)
- Correct_addr_prediction  in  1  predicted target equals the computed target
- perf_clear  in  1  synchronous clear of all counters
- ForwardAE, ForwardBE  out  2 each  bypass selects: 00 regfile, 01 ResultW, 10 ALUOutM
- StallF, StallD  out  1  stall PC register / Decode register
- FlushD, FlushE  out  1  clear Decode / Execute pipeline registers
- BranchTakenE  out  1  redirect PC to ALUResultE
- Branched_wrong  out  1  redirect PC to the saved fall-through address
- BranchTakenE_for_predictor  out  1  actual branch outcome, for predictor update
- branch_cnt, mispredict_cnt, stall_cnt  out  CNT_W each  performance counters

## Operation
- **Forwarding (combinational):**
  - ForwardAE = 10 if Match_1E_M & RegWriteM.
  - Otherwise ForwardAE = 01 if Match_1E_W & RegWriteW.
  - Otherwise ForwardAE = 00.
  - ForwardBE follows the same rule using the Match_2E_* inputs.
- **Branch valid:** brv = BranchE & (state == RUN).
- **Outcome:** BranchTakenE_for_predictor = brv & CondTakenE.
- **Taken redirect:** BranchTakenE = brv & CondTakenE & ~(prediction_E & Correct_addr_prediction). This covers three cases:
  - not predicted but taken;
  - predicted with the wrong target;
  - predicted with a correct target is excluded (no redirect).
- **Fall-through recovery:** Branched_wrong = brv & ~CondTakenE & prediction_E.
- **Misprediction:** mis = BranchTakenE | Branched_wrong. BranchTakenE and Branched_wrong are never both 1.
- **Load-use stall:** ldrstall = Match_12D_E & MemtoRegE & ~mis & (state == RUN).
- **Stall/flush outputs:**
  - StallF = StallD = ldrstall.
  - FlushD = mis.
  - FlushE = mis | ldrstall.
  - When a misprediction coincides with a load-use hazard, the misprediction wins and no stall is issued.
- **FSM states:** RUN and RECOVER.
  - In RUN, mis = 1 moves the FSM to RECOVER at the next edge.
  - RECOVER always returns to RUN after one cycle.
  - In RECOVER, the Execute stage holds a flushed bubble. BranchE is therefore ignored and ldrstall is masked (all outputs above evaluate with brv = 0). Forwarding is unaffected.
- **Counters** (each saturates at 2^CNT_W−1):
  - branch_cnt increments when brv = 1.
  - mispredict_cnt increments when mis = 1.
  - stall_cnt increments when ldrstall = 1.
  - perf_clear = 1 zeroes all three at the next edge and takes priority over any increment in the same cycle.
- **Reset:** state = RUN and all counters = 0. Combinational outputs follow their inputs. With all inputs 0, every output is 0.
- **Reset mid-recovery:** the FSM returns to RUN immediately (asynchronously).

## Timing
- All forward, stall, flush and redirect outputs are combinational with zero-cycle latency. They are valid before the clk edge that captures PCnextF.
- The FSM and counters are registered. A counter reflects an event one clk edge after it occurs.
- Misprediction penalty is 2 cycles: the flush cycle plus the RECOVER cycle. A correctly predicted taken branch has zero penalty.
- A load-use stall holds F/D for one cycle. ldrstall stays asserted for as long as the condition persists; the datapath guarantees it persists for one cycle.
- Counter saturation: at all-ones, an increment leaves the value unchanged with no wrap-around.

## Test plan
- **Forwarding priority:** Match_1E_M=1, RegWriteM=1, Match_1E_W=1, RegWriteW=1 → ForwardAE=10. Then drop RegWriteM → ForwardAE=01. Then drop RegWriteW → ForwardAE=00. Repeat the sequence for ForwardBE.
- **Load-use stall:** MemtoRegE=1, Match_12D_E=1, no branch → StallF=StallD=FlushE=1, FlushD=0. stall_cnt goes 0→1 at the next edge.
- **Misprediction classes:**
  - BranchE=1, CondTakenE=1, prediction_E=0 → BranchTakenE=1, FlushD=FlushE=1. The FSM is in RECOVER next cycle, during which BranchE=1 produces no redirect and does not increment branch_cnt.
  - prediction_E=1, CondTakenE=0 → Branched_wrong=1.
  - prediction_E=1, CondTakenE=1, Correct_addr_prediction=0 → BranchTakenE=1.
  - prediction_E=1, CondTakenE=1, Correct_addr_prediction=1 → no redirect, no flush. branch_cnt +1, mispredict_cnt unchanged.
- **Simultaneous misprediction and load-use:** mispredict with MemtoRegE=1 and Match_12D_E=1 in the same cycle → StallF=StallD=0, FlushD=FlushE=1. stall_cnt is unchanged.
- **Saturation and clear:** with CNT_W=4, issue 17 mispredicts → mispredict_cnt=15. Then assert perf_clear together with a mispredict → all counters read 0.
- **Reset mid-recovery:** assert reset during RECOVER → the next BranchE=1, CondTakenE=1 after release redirects normally and all counters read from 0.
